regfile_wr_arbiter: RTL
=======================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port (r_wr_en / w_reg / w_data) among NUM_REQ writeback requesters.
//  Typical requesters: ALU writeback, load writeback and link-register writeback.
//  Uses round-robin arbitration, a valid/ready handshake on each requester and registered write-port outputs.
//  Sits between the writeback stage(s) and register_file. Drops writes to $zero and counts committed writes.
// PARAMETERS
//  NUM_REQ  3   number of writeback requesters (2..8)
//  ADDR_W   5   register index width
//  DATA_W   32  register data width
//  CNT_W    16  width of the committed-write counter
// PORTS
//  clk        in   1               clock, rising edge
//  rst        in   1               asynchronous, active-low reset
//  req_valid  in   NUM_REQ         requester i holds a write
//  req_ready  out  NUM_REQ         requester i accepted this cycle (one-hot or zero)
//  req_reg    in   NUM_REQ*ADDR_W  destination index; slice i = [i*ADDR_W +: ADDR_W]
//  req_data   in   NUM_REQ*DATA_W  write data; slice i = [i*DATA_W +: DATA_W]
//  stall      in   1               write port frozen; no grants
//  r_wr_en    out  1               write enable to register_file
//  w_reg      out  ADDR_W          write index to register_file
//  w_data     out  DATA_W          write data to register_file
//  last_gnt   out  $clog2(NUM_REQ) index of the most recently granted requester
//  wr_count   out  CNT_W           saturating count of committed (r_wr_en=1) writes
// BEHAVIOUR
//  - Reset (rst=0, async): r_wr_en=0, w_reg=0, w_data=0, wr_count=0, last_gnt=NUM_REQ-1.
//    Requester 0 therefore has first priority after reset. req_ready is low while rst=0.
//  - Grant (combinational): when stall=0, search from last_gnt+1 upward, wrapping modulo NUM_REQ.
//    The first i with req_valid[i]=1 gets req_ready[i]=1; at most one ready bit is set.
//  - Transfer occurs when req_valid[i] & req_ready[i]. On that edge last_gnt<=i.
//  - Requesters hold valid, reg and data stable until transferred. Dropping valid before transfer is illegal.
//  - Latency: write-port outputs are registered, one cycle after the transfer edge.
//    At edge k, w_reg<=req_reg[i] and w_data<=req_data[i]. r_wr_en=1 during cycle k+1 only.
//    register_file commits at edge k+1.
//  - $zero: a transfer with req_reg[i]==0 is accepted (ready=1, last_gnt updates).
//    It drives r_wr_en=0 the next cycle and is not counted.
//  - No transfer in a cycle: r_wr_en<=0. w_reg and w_data hold their previous values.
//  - stall=1: all req_ready=0, last_gnt holds, r_wr_en<=0 at the next edge.
//    A write already registered before stall rose still completes in its cycle.
//  - Same destination from two requesters: no merging. Writes are serialised in grant order; the later grant wins.
//  - Sustained throughput: one write per cycle. With all requesters valid, grants rotate 0,1,2,0,...
//  - wr_count increments by 1 on each edge where r_wr_en=1. It saturates at 2^CNT_W-1 and does not wrap.
//  - Reset mid-operation: any registered write is discarded immediately, r_wr_en falls asynchronously,
//    and pending requests are re-arbitrated from requester 0 after reset release.
//  - NUM_REQ=1: grant = req_valid & ~stall; last_gnt is a constant 0.
// STRUCTURE
//  - Shared package regfile_pkg: ADDR_W, DATA_W, ZERO_REG=0, REG_COUNT=32.
//    regfile_pkg is also imported by register_file users.
//  - Sub-module rr_arbiter #(N): inputs req[N], en, clk, rst. Outputs gnt[N] one-hot and ptr.
//    ptr updates on (en & |req). It holds the rotating-priority logic only.
//  - Top level: grant-to-data mux, $zero filter, output registers, saturating counter.
// TESTING
//  1. Reset: rst=0 with all valid=1 -> req_ready=0, r_wr_en=0, wr_count=0.
//     After release, first grant is req 0.
//  2. Single write: req1 valid, reg=5, data=32'hDEADBEEF.
//     -> ready[1]=1 for 1 cycle. Next cycle r_wr_en=1, w_reg=5, w_data=DEADBEEF. wr_count=1.
//  3. Fairness: all 3 valid and held for 6 cycles (re-asserted after each accept).
//     -> grant order 0,1,2,0,1,2; r_wr_en=1 for 6 consecutive cycles.
//  4. $zero: req0 reg=0, data=32'h1234 -> ready[0]=1, next cycle r_wr_en=0, wr_count unchanged.
//  5. Stall: req2 valid and stall=1 for 3 cycles -> ready=0 and r_wr_en=0 throughout.
//     With stall=0, ready[2]=1 in that same cycle.
//  6. Saturation/reset: CNT_W=4, 20 writes -> wr_count=15.
//     Then rst=0 mid-write -> r_wr_en=0 immediately, wr_count=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants used by the writeback arbiter and register_file users.
package regfile_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int ZERO_REG  = 0;
  localparam int REG_COUNT = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: searches upward from the last winner, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr
);

  if (N == 1) begin : g_single

    assign gnt = req & {N{en}};
    assign ptr = '0;

  end else begin : g_multi

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] win_d;
    logic [PW-1:0] cand;
    logic          found;

    // The first requester after the previous winner takes the grant.
    always_comb begin
      gnt   = '0;
      win_d = ptr_q;
      cand  = '0;
      found = 1'b0;
      for (int off = 1; off <= N; off++) begin
        cand = PW'((int'(ptr_q) + off) % N);
        if (en && !found && req[cand]) begin
          gnt[cand] = 1'b1;
          win_d     = cand;
          found     = 1'b1;
        end
      end
    end

    // Reset points at N-1 so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ptr_q <= PW'(N - 1);
      end else if (en && |req) begin
        ptr_q <= win_d;
      end
    end

    assign ptr = ptr_q;

  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback requesters with
// round-robin grants, registered write outputs, $zero filtering and a write counter.
module regfile_wr_arbiter #(
  parameter int  NUM_REQ = 3,
  parameter int  ADDR_W  = regfile_pkg::ADDR_W,
  parameter int  DATA_W  = regfile_pkg::DATA_W,
  parameter int  CNT_W   = 16,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      stall,
  output logic                      r_wr_en,
  output logic [ADDR_W-1:0]         w_reg,
  output logic [DATA_W-1:0]         w_data,
  output logic [PTR_W-1:0]          last_gnt,
  output logic [CNT_W-1:0]          wr_count
);

  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   ptr;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_data;

  logic               wr_en_q,  wr_en_d;
  logic [ADDR_W-1:0]  w_reg_q,  w_reg_d;
  logic [DATA_W-1:0]  w_data_q, w_data_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (~stall),
    .gnt (gnt),
    .ptr (ptr)
  );

  // Requesters must never see ready while reset is held.
  assign req_ready = gnt & {NUM_REQ{rst}};
  assign xfer      = |req_ready;

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_reg  = sel_reg  | req_reg[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A $zero transfer is still consumed but never reaches the register file.
  always_comb begin
    wr_en_d  = xfer && (sel_reg != ADDR_W'(regfile_pkg::ZERO_REG));
    w_reg_d  = xfer ? sel_reg  : w_reg_q;
    w_data_d = xfer ? sel_data : w_data_q;
    cnt_d    = (wr_en_q && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q  <= 1'b0;
      w_reg_q  <= '0;
      w_data_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_en_q  <= wr_en_d;
      w_reg_q  <= w_reg_d;
      w_data_q <= w_data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign r_wr_en  = wr_en_q;
  assign w_reg    = w_reg_q;
  assign w_data   = w_data_q;
  assign last_gnt = ptr;
  assign wr_count = cnt_q;

endmodule
